// File: rtl/pds_port_agent.sv
// pds_port_agent: per-port device-side front end of the power delivery controller.
// Detects an attached powered device, classifies it into a 2-bit priority,
// requests power from the controller and drives the port power switch.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   pd_sense          device signature present
//   pd_class[1:0]     device class code
//   overcurrent       port current-limit comparator
//   user_off          software hold-off / depower request
//   on_grant          controller's on bit for this port
//   det               valid device waiting for / holding power
//   prio[1:0]         latched priority (3 = highest)
//   off               off request to controller
//   pwr_en            port power switch enable
//   state[2:0]        FSM state (debug)
//   fault             high while in FAULT
//
// Optional build macro PDS_PORT_STATS_EN adds fault_cnt[7:0] and grant_cnt[7:0]
// (saturating counts of FAULT entries and REQ->POWERED transitions).
module pds_port_agent #(
    parameter int unsigned DET_CYCLES     = 4,
    parameter int unsigned CLS_CYCLES     = 2,
    parameter int unsigned OC_CYCLES      = 3,
    parameter int unsigned BACKOFF_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pd_sense,
    input  logic [1:0] pd_class,
    input  logic       overcurrent,
    input  logic       user_off,
    input  logic       on_grant,
    output logic       det,
    output logic [1:0] prio,
    output logic       off,
    output logic       pwr_en,
    output logic [2:0] state,
    output logic       fault
`ifdef PDS_PORT_STATS_EN
    ,
    output logic [7:0] fault_cnt,
    output logic [7:0] grant_cnt
`endif
);

    localparam int unsigned DW = $clog2(DET_CYCLES + 1);
    localparam int unsigned CW = $clog2(CLS_CYCLES + 1);
    localparam int unsigned OW = $clog2(OC_CYCLES + 1);
    localparam int unsigned BW = $clog2(BACKOFF_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DETECT   = 3'd1,
        S_CLASSIFY = 3'd2,
        S_REQ      = 3'd3,
        S_POWERED  = 3'd4,
        S_RELEASE  = 3'd5,
        S_FAULT    = 3'd6
    } state_t;

    state_t        cur_st, nxt_st;
    logic [DW-1:0] det_cnt, det_cnt_n, det_inc;
    logic [CW-1:0] cls_cnt, cls_cnt_n, cls_inc;
    logic [OW-1:0] oc_cnt, oc_cnt_n, oc_inc;
    logic [BW-1:0] bo_cnt, bo_cnt_n, bo_inc;
    logic [1:0]    prev_class;
    logic [1:0]    prio_n;
    logic          det_n, off_n, pwr_en_n, fault_n;

    // Saturating increments so counters never wrap.
    assign det_inc = (det_cnt == DW'(DET_CYCLES))     ? det_cnt : det_cnt + DW'(1);
    assign cls_inc = (cls_cnt == CW'(CLS_CYCLES))     ? cls_cnt : cls_cnt + CW'(1);
    assign oc_inc  = (oc_cnt  == OW'(OC_CYCLES))      ? oc_cnt  : oc_cnt  + OW'(1);
    assign bo_inc  = (bo_cnt  == BW'(BACKOFF_CYCLES)) ? bo_cnt  : bo_cnt  + BW'(1);

    assign state = cur_st;

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_st     <= S_IDLE;
            det_cnt    <= '0;
            cls_cnt    <= '0;
            oc_cnt     <= '0;
            bo_cnt     <= '0;
            prev_class <= '0;
            prio       <= '0;
            det        <= 1'b0;
            off        <= 1'b0;
            pwr_en     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            cur_st     <= nxt_st;
            det_cnt    <= det_cnt_n;
            cls_cnt    <= cls_cnt_n;
            oc_cnt     <= oc_cnt_n;
            bo_cnt     <= bo_cnt_n;
            prev_class <= pd_class;
            prio       <= prio_n;
            det        <= det_n;
            off        <= off_n;
            pwr_en     <= pwr_en_n;
            fault      <= fault_n;
        end
    end

    // Next state, counter updates and next output values.
    always_comb begin
        nxt_st    = cur_st;
        det_cnt_n = '0;
        cls_cnt_n = '0;
        oc_cnt_n  = '0;
        bo_cnt_n  = '0;
        prio_n    = prio;

        case (cur_st)
            S_IDLE: begin
                if (pd_sense && !user_off) begin
                    nxt_st    = S_DETECT;
                    det_cnt_n = DW'(1);
                end
            end
            S_DETECT: begin
                if (!pd_sense) begin
                    nxt_st = S_IDLE;
                end else if (det_inc >= DW'(DET_CYCLES)) begin
                    nxt_st    = S_CLASSIFY;
                    cls_cnt_n = CW'(1);
                end else begin
                    det_cnt_n = det_inc;
                end
            end
            S_CLASSIFY: begin
                if (!pd_sense) begin
                    nxt_st = S_IDLE;
                end else begin
                    // Any change of class restarts the stability count at 1.
                    cls_cnt_n = (pd_class == prev_class) ? cls_inc : CW'(1);
                    if (cls_cnt_n >= CW'(CLS_CYCLES)) begin
                        prio_n    = pd_class;
                        nxt_st    = S_REQ;
                        cls_cnt_n = '0;
                    end
                end
            end
            S_REQ: begin
                if (!pd_sense)     nxt_st = S_IDLE;
                else if (user_off) nxt_st = S_RELEASE;
                else if (on_grant) nxt_st = S_POWERED;
            end
            S_POWERED: begin
                // Fault threshold > pd_sense drop > user_off > grant revoke.
                if (overcurrent && (oc_inc >= OW'(OC_CYCLES))) begin
                    nxt_st = S_FAULT;
                end else if (!pd_sense || user_off) begin
                    nxt_st = S_RELEASE;
                end else if (!on_grant) begin
                    nxt_st = S_REQ;
                end else if (overcurrent) begin
                    oc_cnt_n = oc_inc;
                end
            end
            S_RELEASE: begin
                if (!on_grant && !user_off) nxt_st = S_IDLE;
            end
            S_FAULT: begin
                // Backoff must complete and the controller must have dropped the grant.
                if ((bo_inc >= BW'(BACKOFF_CYCLES)) && !on_grant) begin
                    nxt_st = S_IDLE;
                end else begin
                    bo_cnt_n = bo_inc;
                end
            end
            default: nxt_st = S_IDLE;
        endcase

        det_n    = (nxt_st == S_REQ) || (nxt_st == S_POWERED);
        pwr_en_n = (nxt_st == S_POWERED);
        off_n    = (nxt_st == S_RELEASE) || (nxt_st == S_FAULT);
        fault_n  = (nxt_st == S_FAULT);
    end

`ifdef PDS_PORT_STATS_EN
    // Saturating event counters for fault entries and granted power-ups.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_cnt <= '0;
            grant_cnt <= '0;
        end else begin
            if ((nxt_st == S_FAULT) && (cur_st != S_FAULT) && (fault_cnt != 8'hFF))
                fault_cnt <= fault_cnt + 8'd1;
            if ((cur_st == S_REQ) && (nxt_st == S_POWERED) && (grant_cnt != 8'hFF))
                grant_cnt <= grant_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pds_port_agent.sv
// tb_pds_port_agent: self-checking bench for pds_port_agent.
// Expected outputs are queued as each stimulus cycle is driven and popped
// and compared once the DUT has clocked that cycle.
module tb_pds_port_agent;

    logic       clk;
    logic       rst;
    logic       pd_sense;
    logic [1:0] pd_class;
    logic       overcurrent;
    logic       user_off;
    logic       on_grant;
    logic       det;
    logic [1:0] prio;
    logic       off;
    logic       pwr_en;
    logic [2:0] state;
    logic       fault;
`ifdef PDS_PORT_STATS_EN
    logic [7:0] fault_cnt;
    logic [7:0] grant_cnt;
`endif

    pds_port_agent dut (
        .clk         (clk),
        .rst         (rst),
        .pd_sense    (pd_sense),
        .pd_class    (pd_class),
        .overcurrent (overcurrent),
        .user_off    (user_off),
        .on_grant    (on_grant),
        .det         (det),
        .prio        (prio),
        .off         (off),
        .pwr_en      (pwr_en),
        .state       (state),
        .fault       (fault)
`ifdef PDS_PORT_STATS_EN
        ,
        .fault_cnt   (fault_cnt),
        .grant_cnt   (grant_cnt)
`endif
    );

    typedef struct {
        string      nm;
        logic [2:0] st;
        logic       d;
        logic [1:0] p;
        logic       of;
        logic       pe;
        logic       f;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] cur_prio = 2'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, queue the expected outputs, clock, then pop and compare.
    task automatic cyc(input logic s, input logic [1:0] c, input logic o, input logic u,
                       input logic g, input string nm, input logic [2:0] st, input logic d,
                       input logic [1:0] p, input logic of, input logic pe, input logic f);
        exp_t e;
        exp_t a;
        pd_sense    = s;
        pd_class    = c;
        overcurrent = o;
        user_off    = u;
        on_grant    = g;
        e.nm = nm; e.st = st; e.d = d; e.p = p; e.of = of; e.pe = pe; e.f = f;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        a = sb_q.pop_front();
        n_vec++;
        if ({state, det, prio, off, pwr_en, fault} !== {a.st, a.d, a.p, a.of, a.pe, a.f}) begin
            n_err++;
            $display("FAIL %s: got st=%0d det=%b prio=%0d off=%b pwr_en=%b fault=%b, want st=%0d det=%b prio=%0d off=%b pwr_en=%b fault=%b",
                     a.nm, state, det, prio, off, pwr_en, fault, a.st, a.d, a.p, a.of, a.pe, a.f);
        end
    endtask

    // IDLE -> DETECT x4 -> CLASSIFY -> REQ (one held cycle) -> POWERED.
    task automatic go_powered(input logic [1:0] cls);
        cyc(1, cls, 0, 0, 0, "gp det1", 3'd1, 0, cur_prio, 0, 0, 0);
        cyc(1, cls, 0, 0, 0, "gp det2", 3'd1, 0, cur_prio, 0, 0, 0);
        cyc(1, cls, 0, 0, 0, "gp det3", 3'd1, 0, cur_prio, 0, 0, 0);
        cyc(1, cls, 0, 0, 0, "gp det4", 3'd2, 0, cur_prio, 0, 0, 0);
        cur_prio = cls;
        cyc(1, cls, 0, 0, 0, "gp cls",   3'd3, 1, cur_prio, 0, 0, 0);
        cyc(1, cls, 0, 0, 0, "gp req",   3'd3, 1, cur_prio, 0, 0, 0);
        cyc(1, cls, 0, 0, 1, "gp grant", 3'd4, 1, cur_prio, 0, 1, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pd_sense = 0; pd_class = 0; overcurrent = 0; user_off = 0; on_grant = 0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({state, det, prio, off, pwr_en, fault} !== 9'd0) begin
            n_err++;
            $display("FAIL reset: got st=%0d det=%b prio=%0d off=%b pwr_en=%b fault=%b, want all 0",
                     state, det, prio, off, pwr_en, fault);
        end
`ifdef PDS_PORT_STATS_EN
        n_vec++;
        if ({fault_cnt, grant_cnt} !== 16'd0) begin
            n_err++;
            $display("FAIL reset stats: got fault_cnt=%0d grant_cnt=%0d, want 0 0", fault_cnt, grant_cnt);
        end
`endif
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, "idle after reset", 3'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_detect_grant();
        go_powered(2'd2);
        cyc(0, 2, 0, 0, 1, "sense drop",  3'd5, 0, 2, 1, 0, 0);
        cyc(0, 2, 0, 0, 0, "release end", 3'd0, 0, 2, 0, 0, 0);
    endtask

    task automatic test_false_detect();
        cyc(1, 1, 0, 0, 0, "fd det1", 3'd1, 0, 2, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "fd det2", 3'd1, 0, 2, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "fd det3", 3'd1, 0, 2, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, "fd drop", 3'd0, 0, 2, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc(1, 1, 0, 0, 0, "tg det", (i == 3) ? 3'd2 : 3'd1, 0, 2, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            cyc(1, (i % 2 == 0) ? 2'd2 : 2'd1, 0, 0, 0, "tg toggle", 3'd2, 0, 2, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, "tg drop", 3'd0, 0, 2, 0, 0, 0);
    endtask

    task automatic test_fault();
        go_powered(2'd3);
        cyc(1, 3, 1, 0, 1, "oc1", 3'd4, 1, 3, 0, 1, 0);
        cyc(1, 3, 1, 0, 1, "oc2", 3'd4, 1, 3, 0, 1, 0);
        cyc(1, 3, 1, 0, 1, "oc3", 3'd6, 0, 3, 1, 0, 1);
        // Grant held past the backoff: FAULT must persist with off high.
        for (int i = 0; i < 10; i++)
            cyc(0, 3, 0, 0, 1, "fault grant held", 3'd6, 0, 3, 1, 0, 1);
        cyc(0, 3, 0, 0, 0, "fault grant drop", 3'd0, 0, 3, 0, 0, 0);
        // Grant dropped immediately: exit exactly after 8 backoff cycles.
        go_powered(2'd3);
        cyc(1, 3, 1, 0, 1, "oc1b", 3'd4, 1, 3, 0, 1, 0);
        cyc(1, 3, 1, 0, 1, "oc2b", 3'd4, 1, 3, 0, 1, 0);
        cyc(1, 3, 1, 0, 1, "oc3b", 3'd6, 0, 3, 1, 0, 1);
        for (int i = 1; i < 8; i++)
            cyc(0, 3, 0, 0, 0, "backoff", 3'd6, 0, 3, 1, 0, 1);
        cyc(0, 3, 0, 0, 0, "backoff done", 3'd0, 0, 3, 0, 0, 0);
    endtask

    task automatic test_stats();
`ifdef PDS_PORT_STATS_EN
        n_vec++;
        if (fault_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL fault_cnt: got %0d, want 2", fault_cnt);
        end
        n_vec++;
        if (grant_cnt !== 8'd3) begin
            n_err++;
            $display("FAIL grant_cnt: got %0d, want 3", grant_cnt);
        end
`endif
    endtask

    task automatic test_oc_glitch();
        logic oc_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        go_powered(2'd1);
        for (int i = 0; i < 6; i++)
            cyc(1, 1, oc_pat[i], 0, 1, "oc glitch", 3'd4, 1, 1, 0, 1, 0);
    endtask

    task automatic test_revoke();
        cyc(1, 1, 0, 0, 0, "revoke",      3'd3, 1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "revoke hold", 3'd3, 1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, "regrant",     3'd4, 1, 1, 0, 1, 0);
    endtask

    task automatic test_user_off_reset();
        cyc(1, 1, 0, 1, 1, "uoff",          3'd5, 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 1, 1, "uoff hold",     3'd5, 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 1, "rel grant hi",  3'd5, 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, "rel uoff hi",   3'd5, 0, 1, 1, 0, 0);
        // Asynchronous reset mid-RELEASE, checked without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({state, det, prio, off, pwr_en, fault} !== 9'd0) begin
            n_err++;
            $display("FAIL async reset: got st=%0d det=%b prio=%0d off=%b pwr_en=%b fault=%b, want all 0",
                     state, det, prio, off, pwr_en, fault);
        end
        cur_prio = 2'd0;
        pd_sense = 0; user_off = 0; on_grant = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, "post reset idle", 3'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_release_exit();
        go_powered(2'd2);
        cyc(1, 2, 0, 1, 1, "uoff2",         3'd5, 0, 2, 1, 0, 0);
        cyc(1, 2, 0, 0, 0, "both drop",     3'd0, 0, 2, 0, 0, 0);
        cyc(1, 2, 0, 1, 0, "uoff blocks",   3'd0, 0, 2, 0, 0, 0);
        cyc(1, 2, 0, 0, 0, "uoff released", 3'd1, 0, 2, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_detect_grant();
        test_false_detect();
        test_fault();
        test_stats();
        test_oc_glitch();
        test_revoke();
        test_user_off_reset();
        test_release_exit();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", n_vec);
        $fatal(1);
    end

endmodule
